// File: rtl/mul8_seq_pkg.sv
// Shared types and constants for the 8x8 sequential multiplier.
// FSM encodings and the final iteration index.
package mul8_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] MUL8_ITER = 3'd7;

endpackage

// File: rtl/add8.sv
// 8-bit ripple-carry adder; Overflow is the unsigned carry out.
// Combinational, one full-adder cell per bit.
module add8 (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       C0,
  output logic [7:0] SUM,
  output logic       Overflow
);

  logic [8:0] w_c;

  assign w_c[0] = C0;

  for (genvar g = 0; g < 8; g++) begin : g_fa
    assign SUM[g]   = A[g] ^ B[g] ^ w_c[g];
    assign w_c[g+1] = (A[g] & B[g]) |
                      (w_c[g] & (A[g] ^ B[g]));
  end

  assign Overflow = w_c[8];

endmodule

// File: rtl/mul8_seq.sv
// Unsigned 8x8 shift-and-add multiplier, one add8 pass per cycle.
// Start/busy/done handshake, 8 iterations per product.
module mul8_seq
  import mul8_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  a_in,
  input  logic [7:0]  b_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_mcand;
  logic [7:0]  w_mcand_nxt;
  logic [15:0] r_p;
  logic [15:0] w_p_nxt;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_nxt;
  logic [15:0] r_product;
  logic [15:0] w_product_nxt;

  logic [7:0]  w_b;
  logic [7:0]  w_sum;
  logic        w_cout;
  logic [15:0] w_p_step;

  assign w_b = r_p[0] ? r_mcand : 8'h00;

  add8 u_add8 (
    .A        (r_p[15:8]),
    .B        (w_b),
    .C0       (1'b0),
    .SUM      (w_sum),
    .Overflow (w_cout)
  );

  // carry lands in bit 15 as the pair shifts right
  assign w_p_step = {w_cout, w_sum, r_p[7:1]};

  always_comb begin
    w_state_nxt   = r_state;
    w_mcand_nxt   = r_mcand;
    w_p_nxt       = r_p;
    w_cnt_nxt     = r_cnt;
    w_product_nxt = r_product;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_mcand_nxt = a_in;
          w_p_nxt     = {8'h00, b_in};
          w_cnt_nxt   = 3'd0;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_p_nxt   = w_p_step;
        w_cnt_nxt = r_cnt + 3'd1;
        if (r_cnt == MUL8_ITER) begin
          w_product_nxt = w_p_step;
          w_state_nxt   = S_DONE;
        end
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_mcand   <= 8'h00;
      r_p       <= 16'h0000;
      r_cnt     <= 3'd0;
      r_product <= 16'h0000;
    end else begin
      r_state   <= w_state_nxt;
      r_mcand   <= w_mcand_nxt;
      r_p       <= w_p_nxt;
      r_cnt     <= w_cnt_nxt;
      r_product <= w_product_nxt;
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign product = r_product;

endmodule

// File: tb/tb_mul8_seq.sv
// Directed bench for mul8_seq: latency, handshake, reset abort.
// Expected products are hand-computed constants or a*b.
module tb_mul8_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int n_assert = 0;
  int n_fail   = 0;

  mul8_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Called just after a posedge while IDLE; returns just after E0.
  task automatic do_start(input logic [7:0] a,
                          input logic [7:0] b);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in  = 8'($urandom);
    b_in  = 8'($urandom);
  endtask

  // Counts posedges until done is seen; product must hold meanwhile.
  task automatic wait_done(input string tag, output int n);
    logic [15:0] prev;
    bit          got;
    prev = product;
    got  = 1'b0;
    n    = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      chk({tag, "_hold"}, {16'h0, product}, {16'h0, prev});
      @(posedge clk);
      n++;
    end
    chk({tag, "_seen"}, {31'h0, got}, 32'h1);
  endtask

  task automatic run_mul(input string tag,
                         input logic [7:0] a,
                         input logic [7:0] b);
    int n;
    logic [15:0] exp;
    exp = 16'(a) * 16'(b);
    do_start(a, b);
    chk({tag, "_busy_up"}, {31'h0, busy}, 32'h1);
    wait_done(tag, n);
    chk({tag, "_lat"}, n, 32'd8);
    chk({tag, "_prod"}, {16'h0, product}, {16'h0, exp});
    chk({tag, "_busy_done"}, {31'h0, busy}, 32'h1);
    @(posedge clk);
    #1;
    chk({tag, "_busy_dn"}, {31'h0, busy}, 32'h0);
    chk({tag, "_done_dn"}, {31'h0, done}, 32'h0);
  endtask

  task automatic no_done(input string tag, input int cycles);
    int cnt;
    cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk(tag, cnt, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = 8'h00;
    b_in  = 8'h00;
    #22;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_prod", {16'h0, product}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_mul("zero", 8'h00, 8'h00);
    run_mul("ffff", 8'hFF, 8'hFF);
    chk("ffff_const", {16'h0, product}, 32'hFE01);

    // back-to-back: start is held through DONE, accepted in IDLE
    do_start(8'h0D, 8'h0B);
    wait_done("b2b_a", n);
    chk("b2b_a_lat", n, 32'd8);
    chk("b2b_a_prod", {16'h0, product}, 32'h008F);
    start = 1'b1;
    a_in  = 8'h80;
    b_in  = 8'h03;
    @(posedge clk);
    #1;
    chk("b2b_ign_done", {31'h0, busy}, 32'h0);
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in  = 8'h55;
    b_in  = 8'hAA;
    chk("b2b_b_busy", {31'h0, busy}, 32'h1);
    wait_done("b2b_b", n);
    chk("b2b_b_lat", n, 32'd8);
    chk("b2b_b_prod", {16'h0, product}, 32'h0180);
    @(posedge clk);
    #1;

    // start pulsed mid-run must be ignored
    do_start(8'h07, 8'h09);
    @(posedge clk);
    @(posedge clk);
    #1;
    start = 1'b1;
    a_in  = 8'h11;
    b_in  = 8'h22;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ign", n);
    chk("ign_lat", n, 32'd5);
    chk("ign_prod", {16'h0, product}, 32'h003F);
    @(posedge clk);
    #1;
    no_done("ign_single", 12);
    chk("ign_idle", {31'h0, busy}, 32'h0);

    // async reset at iteration 4 aborts the operation
    do_start(8'hFF, 8'hFF);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_done", {31'h0, done}, 32'h0);
    chk("abort_prod", {16'h0, product}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    no_done("abort_nodone", 12);
    chk("abort_idle", {31'h0, busy}, 32'h0);
    chk("abort_prod2", {16'h0, product}, 32'h0);
    run_mul("fresh", 8'h02, 8'h03);
    chk("fresh_const", {16'h0, product}, 32'h0006);

    run_mul("a1b1", 8'h01, 8'h01);
    run_mul("a80b80", 8'h80, 8'h80);
    run_mul("aFFb01", 8'hFF, 8'h01);
    run_mul("a01bFF", 8'h01, 8'hFF);
    run_mul("aA5b5A", 8'hA5, 8'h5A);

    for (int i = 0; i < 200; i++) begin
      run_mul("rnd", 8'($urandom), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
